// File: rtl/scoreboard_pkg.sv
// Shared types and sizing for the in-flight instruction scoreboard.
// Entry, exception and functional-unit types are common to decode, issue and commit.
package scoreboard_pkg;

  localparam int unsigned NR_SB_ENTRIES = 4;
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);
  localparam int unsigned NR_WB_PORTS   = 3;

  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

  typedef enum logic [2:0] {
    NONE,
    LOAD,
    STORE,
    ALU,
    CTRL_FLOW,
    MULT,
    CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    fu_t                      fu;
    logic [6:0]               op;
    logic [4:0]               rs1;
    logic [4:0]               rs2;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception                 ex;
  } scoreboard_entry;

endpackage

// File: rtl/scoreboard_if.sv
// Decode, issue, forwarding, write-back and commit signals of the scoreboard.
// The slave modport is the scoreboard itself; master is its surrounding pipeline.
interface scoreboard_if;
  import scoreboard_pkg::*;

  logic                                      flush;
  logic                                      full;

  scoreboard_entry                           decoded_instr;
  logic                                      decoded_instr_valid;
  logic                                      decoded_instr_ack;

  scoreboard_entry                           issue_instr;
  logic                                      issue_instr_valid;
  logic                                      issue_ack;

  logic [4:0]                                rs1_reg;
  logic [4:0]                                rs2_reg;
  logic [63:0]                               rs1_data;
  logic [63:0]                               rs2_data;
  logic                                      rs1_valid;
  logic                                      rs2_valid;

  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id;
  logic [NR_WB_PORTS-1:0][63:0]              wb_data;
  logic [NR_WB_PORTS-1:0]                    wb_valid;
  exception [NR_WB_PORTS-1:0]                wb_ex;

  scoreboard_entry                           commit_instr;
  logic                                      commit_valid;
  logic                                      commit_ack;

  modport slave (
    input  flush, decoded_instr, decoded_instr_valid, issue_ack,
           rs1_reg, rs2_reg, wb_trans_id, wb_data, wb_valid, wb_ex, commit_ack,
    output full, decoded_instr_ack, issue_instr, issue_instr_valid,
           rs1_data, rs2_data, rs1_valid, rs2_valid, commit_instr, commit_valid
  );

  modport master (
    output flush, decoded_instr, decoded_instr_valid, issue_ack,
           rs1_reg, rs2_reg, wb_trans_id, wb_data, wb_valid, wb_ex, commit_ack,
    input  full, decoded_instr_ack, issue_instr, issue_instr_valid,
           rs1_data, rs2_data, rs1_valid, rs2_valid, commit_instr, commit_valid
  );

endinterface

// File: rtl/scoreboard.sv
// Circular buffer of in-flight instructions: allocates trans_ids at decode, collects
// write-back results/exceptions, and presents issue, commit and operand forwarding.
module scoreboard #(
  parameter int unsigned NR_ENTRIES  = scoreboard_pkg::NR_SB_ENTRIES,
  parameter int unsigned NR_WB_PORTS = scoreboard_pkg::NR_WB_PORTS
) (
  input logic         clk,
  input logic         rst,
  scoreboard_if.slave sb
);
  import scoreboard_pkg::*;

  scoreboard_entry          mem [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] decode_ptr;
  logic [TRANS_ID_BITS-1:0] issue_ptr;
  logic [TRANS_ID_BITS-1:0] commit_ptr;
  logic [TRANS_ID_BITS:0]   cnt;
  logic [TRANS_ID_BITS:0]   issue_cnt;
  logic [TRANS_ID_BITS:0]   issued;

  logic            alloc;
  logic            issue_fire;
  logic            commit_fire;
  scoreboard_entry new_entry;

  assign sb.full              = (cnt == (TRANS_ID_BITS+1)'(NR_ENTRIES));
  assign sb.decoded_instr_ack = !sb.full;
  assign sb.issue_instr       = mem[issue_ptr];
  assign sb.issue_instr_valid = (issue_cnt != '0);
  assign sb.commit_instr      = mem[commit_ptr];
  assign sb.commit_valid      = (cnt != '0);

  assign alloc       = sb.decoded_instr_valid && !sb.full;
  assign issue_fire  = sb.issue_ack && sb.issue_instr_valid;
  assign commit_fire = sb.commit_ack && sb.commit_valid;
  assign issued      = cnt - issue_cnt;

  always_comb begin
    new_entry          = sb.decoded_instr;
    new_entry.trans_id = decode_ptr;
    new_entry.valid    = 1'b0;
  end

  // An id is live when its distance from the commit pointer is inside the occupancy.
  function automatic logic in_flight(input logic [TRANS_ID_BITS-1:0] tid);
    logic [TRANS_ID_BITS-1:0] off;
    off = tid - commit_ptr;
    return ({1'b0, off} < cnt);
  endfunction

  // Walk issued entries oldest to youngest so the youngest writer of rs decides.
  function automatic logic [64:0] fwd(input logic [4:0] rs);
    logic                     hit;
    logic [63:0]              data;
    logic [TRANS_ID_BITS-1:0] idx;
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      idx = commit_ptr + TRANS_ID_BITS'(i);
      if (((TRANS_ID_BITS+1)'(i) < issued) && (mem[idx].rd == rs)) begin
        hit  = mem[idx].valid;
        data = mem[idx].result;
      end
    end
    hit = hit && (rs != 5'd0);
    return {hit, (hit ? data : 64'd0)};
  endfunction

  assign {sb.rs1_valid, sb.rs1_data} = fwd(sb.rs1_reg);
  assign {sb.rs2_valid, sb.rs2_data} = fwd(sb.rs2_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR_ENTRIES; i++) mem[i] <= '0;
      decode_ptr <= '0;
      issue_ptr  <= '0;
      commit_ptr <= '0;
      cnt        <= '0;
      issue_cnt  <= '0;
    end else if (sb.flush) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        mem[i].valid    <= 1'b0;
        mem[i].ex.valid <= 1'b0;
      end
      decode_ptr <= '0;
      issue_ptr  <= '0;
      commit_ptr <= '0;
      cnt        <= '0;
      issue_cnt  <= '0;
    end else begin
      if (alloc) begin
        mem[decode_ptr] <= new_entry;
        decode_ptr      <= decode_ptr + 1;
      end
      // Later ports are applied last, so the highest index wins on a shared id.
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (sb.wb_valid[p] && in_flight(sb.wb_trans_id[p])) begin
          mem[sb.wb_trans_id[p]].result <= sb.wb_data[p];
          mem[sb.wb_trans_id[p]].valid  <= 1'b1;
          if (sb.wb_ex[p].valid) mem[sb.wb_trans_id[p]].ex <= sb.wb_ex[p];
        end
      end
      if (issue_fire) issue_ptr <= issue_ptr + 1;
      if (commit_fire) begin
        mem[commit_ptr].valid <= 1'b0;
        commit_ptr            <= commit_ptr + 1;
      end
      case ({alloc, commit_fire})
        2'b10:   cnt <= cnt + 1;
        2'b01:   cnt <= cnt - 1;
        default: cnt <= cnt;
      endcase
      case ({alloc, issue_fire})
        2'b10:   issue_cnt <= issue_cnt + 1;
        2'b01:   issue_cnt <= issue_cnt - 1;
        default: issue_cnt <= issue_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard: allocation, wrap, forwarding, write-back
// priority, unallocated write-back and flush.
module tb_scoreboard;
  import scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  scoreboard_if sb_if ();

  scoreboard dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb_if.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry mk(input logic [4:0] rd, input logic [63:0] res);
    scoreboard_entry e;
    e          = '0;
    e.pc       = 64'h1000 + {59'd0, rd};
    e.fu       = ALU;
    e.rd       = rd;
    e.rs1      = rd;
    e.result   = res;
    e.trans_id = '1;
    e.valid    = 1'b1;
    return e;
  endfunction

  task automatic idle();
    sb_if.flush               = 1'b0;
    sb_if.decoded_instr       = '0;
    sb_if.decoded_instr_valid = 1'b0;
    sb_if.issue_ack           = 1'b0;
    sb_if.commit_ack          = 1'b0;
    sb_if.wb_valid            = '0;
    sb_if.wb_trans_id         = '0;
    sb_if.wb_data             = '0;
    sb_if.wb_ex               = '0;
  endtask

  task automatic wb(input int p, input logic [1:0] id, input logic [63:0] data,
                    input logic exv);
    sb_if.wb_valid[p]     = 1'b1;
    sb_if.wb_trans_id[p]  = id;
    sb_if.wb_data[p]      = data;
    sb_if.wb_ex[p].cause  = exv ? ILLEGAL_INSTR : 64'd0;
    sb_if.wb_ex[p].tval   = exv ? 64'h77 : 64'd0;
    sb_if.wb_ex[p].valid  = exv;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [63:0] res);
    sb_if.decoded_instr       = mk(rd, res);
    sb_if.decoded_instr_valid = 1'b1;
    tick();
    sb_if.decoded_instr_valid = 1'b0;
  endtask

  task automatic issue_n(input int n);
    sb_if.issue_ack = 1'b1;
    for (int i = 0; i < n; i++) tick();
    sb_if.issue_ack = 1'b0;
  endtask

  task automatic do_flush();
    sb_if.flush = 1'b1;
    tick();
    sb_if.flush = 1'b0;
  endtask

  initial begin
    idle();
    sb_if.rs1_reg = 5'd3;
    sb_if.rs2_reg = 5'd0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_full",         64'(sb_if.full), 64'd0);
    chk("rst_ack",          64'(sb_if.decoded_instr_ack), 64'd1);
    chk("rst_issue_valid",  64'(sb_if.issue_instr_valid), 64'd0);
    chk("rst_commit_valid", 64'(sb_if.commit_valid), 64'd0);
    chk("rst_rs1_valid",    64'(sb_if.rs1_valid), 64'd0);
    chk("rst_rs1_data",     sb_if.rs1_data, 64'd0);
    chk("rst_issue_zero",   64'(sb_if.issue_instr == '0), 64'd1);
    chk("rst_commit_zero",  64'(sb_if.commit_instr == '0), 64'd1);

    // Fill the buffer with rd=1..4
    for (int i = 0; i < 4; i++) begin
      sb_if.decoded_instr       = mk(5'(i + 1), 64'd0);
      sb_if.decoded_instr_valid = 1'b1;
      chk("fill_ack", 64'(sb_if.decoded_instr_ack), 64'd1);
      tick();
    end
    chk("fill_full", 64'(sb_if.full), 64'd1);
    chk("fill_ack_low", 64'(sb_if.decoded_instr_ack), 64'd0);
    sb_if.decoded_instr = mk(5'd9, 64'd0);
    tick();
    sb_if.decoded_instr_valid = 1'b0;
    chk("fifth_rejected_full", 64'(sb_if.full), 64'd1);
    chk("commit_valid",        64'(sb_if.commit_valid), 64'd1);
    chk("commit_tid0",         64'(sb_if.commit_instr.trans_id), 64'd0);
    chk("commit_valid_clear",  64'(sb_if.commit_instr.valid), 64'd0);
    chk("commit_pc",           sb_if.commit_instr.pc, 64'h1001);

    for (int i = 0; i < 4; i++) begin
      chk("issue_valid", 64'(sb_if.issue_instr_valid), 64'd1);
      chk("issue_tid",   64'(sb_if.issue_instr.trans_id), 64'(i));
      chk("issue_rd",    64'(sb_if.issue_instr.rd), 64'(i + 1));
      sb_if.issue_ack = 1'b1;
      tick();
    end
    sb_if.issue_ack = 1'b0;
    chk("issue_drained", 64'(sb_if.issue_instr_valid), 64'd0);

    // Full buffer: commit and allocate together -> no allocate this cycle
    sb_if.decoded_instr       = mk(5'd7, 64'd0);
    sb_if.decoded_instr_valid = 1'b1;
    sb_if.commit_ack          = 1'b1;
    tick();
    sb_if.commit_ack = 1'b0;
    chk("nobypass_full",  64'(sb_if.full), 64'd0);
    chk("nobypass_issue", 64'(sb_if.issue_instr_valid), 64'd0);
    chk("nobypass_ctid",  64'(sb_if.commit_instr.trans_id), 64'd1);
    tick();
    sb_if.decoded_instr_valid = 1'b0;
    chk("wrap_issue_valid", 64'(sb_if.issue_instr_valid), 64'd1);
    chk("wrap_tid",         64'(sb_if.issue_instr.trans_id), 64'd0);
    chk("wrap_rd",          64'(sb_if.issue_instr.rd), 64'd7);
    chk("wrap_full",        64'(sb_if.full), 64'd1);
    do_flush();
    chk("flush1_commit_valid", 64'(sb_if.commit_valid), 64'd0);

    // Forwarding: two writers of x5
    alloc(5'd5, 64'd0);
    alloc(5'd5, 64'd0);
    issue_n(2);
    sb_if.rs1_reg = 5'd5;
    sb_if.rs2_reg = 5'd5;
    #1;
    chk("fwd_none_valid", 64'(sb_if.rs1_valid), 64'd0);
    wb(0, 2'd1, 64'hDEAD, 1'b0);
    tick();
    idle();
    chk("fwd_young_valid", 64'(sb_if.rs1_valid), 64'd1);
    chk("fwd_young_data",  sb_if.rs1_data, 64'hDEAD);
    wb(0, 2'd0, 64'hBEEF, 1'b0);
    tick();
    idle();
    chk("fwd_keep_young", sb_if.rs1_data, 64'hDEAD);
    chk("commit_result",  sb_if.commit_instr.result, 64'hBEEF);
    chk("commit_res_vld", 64'(sb_if.commit_instr.valid), 64'd1);
    alloc(5'd5, 64'd0);
    issue_n(1);
    chk("fwd_young_pending_valid", 64'(sb_if.rs1_valid), 64'd0);
    chk("fwd_young_pending_data",  sb_if.rs1_data, 64'd0);
    chk("fwd_rs2_pending",         64'(sb_if.rs2_valid), 64'd0);
    wb(1, 2'd2, 64'h1234, 1'b0);
    tick();
    idle();
    chk("fwd_rs2_valid", 64'(sb_if.rs2_valid), 64'd1);
    chk("fwd_rs2_data",  sb_if.rs2_data, 64'h1234);
    alloc(5'd0, 64'd0);
    issue_n(1);
    wb(0, 2'd3, 64'h55, 1'b0);
    tick();
    idle();
    sb_if.rs1_reg = 5'd0;
    #1;
    chk("fwd_x0_valid", 64'(sb_if.rs1_valid), 64'd0);
    chk("fwd_x0_data",  sb_if.rs1_data, 64'd0);
    do_flush();

    // Write-back priority, exception capture, unallocated write-back
    alloc(5'd10, 64'd0);
    alloc(5'd11, 64'd0);
    alloc(5'd12, 64'd0);
    issue_n(3);
    sb_if.decoded_instr       = mk(5'd13, 64'hAAAA);
    sb_if.decoded_instr_valid = 1'b1;
    wb(0, 2'd2, 64'h1111, 1'b0);
    wb(1, 2'd3, 64'h3333, 1'b0);
    wb(2, 2'd2, 64'h2222, 1'b1);
    tick();
    idle();
    sb_if.rs1_reg = 5'd12;
    sb_if.rs2_reg = 5'd13;
    #1;
    chk("prio_fwd_data",  sb_if.rs1_data, 64'h2222);
    chk("prio_fwd_valid", 64'(sb_if.rs1_valid), 64'd1);
    chk("unissued_no_fwd", 64'(sb_if.rs2_valid), 64'd0);
    sb_if.commit_ack = 1'b1;
    tick();
    tick();
    sb_if.commit_ack = 1'b0;
    chk("prio_tid",      64'(sb_if.commit_instr.trans_id), 64'd2);
    chk("prio_result",   sb_if.commit_instr.result, 64'h2222);
    chk("prio_valid",    64'(sb_if.commit_instr.valid), 64'd1);
    chk("prio_ex_valid", 64'(sb_if.commit_instr.ex.valid), 64'd1);
    chk("prio_ex_cause", sb_if.commit_instr.ex.cause, ILLEGAL_INSTR);
    chk("prio_ex_tval",  sb_if.commit_instr.ex.tval, 64'h77);
    sb_if.commit_ack = 1'b1;
    tick();
    sb_if.commit_ack = 1'b0;
    chk("fwd_after_commit", 64'(sb_if.rs1_valid), 64'd0);
    chk("unalloc_tid",    64'(sb_if.commit_instr.trans_id), 64'd3);
    chk("unalloc_result", sb_if.commit_instr.result, 64'hAAAA);
    chk("unalloc_valid",  64'(sb_if.commit_instr.valid), 64'd0);

    // Flush coincident with allocate, write-back, issue and commit
    alloc(5'd14, 64'd0);
    alloc(5'd15, 64'd0);
    sb_if.flush               = 1'b1;
    sb_if.decoded_instr       = mk(5'd16, 64'd0);
    sb_if.decoded_instr_valid = 1'b1;
    sb_if.commit_ack          = 1'b1;
    sb_if.issue_ack           = 1'b1;
    wb(0, 2'd0, 64'h9999, 1'b1);
    tick();
    idle();
    chk("flush_commit_valid", 64'(sb_if.commit_valid), 64'd0);
    chk("flush_issue_valid",  64'(sb_if.issue_instr_valid), 64'd0);
    chk("flush_full",         64'(sb_if.full), 64'd0);
    chk("flush_ack",          64'(sb_if.decoded_instr_ack), 64'd1);
    alloc(5'd20, 64'd0);
    chk("post_flush_issue_tid",  64'(sb_if.issue_instr.trans_id), 64'd0);
    chk("post_flush_commit_tid", 64'(sb_if.commit_instr.trans_id), 64'd0);
    chk("post_flush_rd",         64'(sb_if.commit_instr.rd), 64'd20);
    chk("post_flush_ex",         64'(sb_if.commit_instr.ex.valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard.md
# scoreboard

Tracks every in-flight instruction between decode and commit in a circular buffer of `NR_SB_ENTRIES` `scoreboard_entry` records. It sits directly downstream of the decoder and upstream of issue, the functional units and commit. It allocates the `trans_id` for each instruction and collects results and exceptions from the write-back ports. It presents the oldest entry to commit in program order and forwards completed results to issue.

## Interface
- `NR_ENTRIES`, default `ariane_pkg::NR_SB_ENTRIES` (4): buffer depth, power of two.
- `NR_WB_PORTS`, default `ariane_pkg::NR_WB_PORTS` (3): number of write-back ports.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `flush_i` in 1: discard all entries.
- `full_o` out 1: no free entry.
- `decoded_instr_i` in `scoreboard_entry`: instruction from decode.
- `decoded_instr_valid_i` in 1: decode offers an instruction.
- `decoded_instr_ack_o` out 1: instruction accepted; equals `!full_o`.
- `issue_instr_o` out `scoreboard_entry`: oldest not-yet-issued entry.
- `issue_instr_valid_o` out 1: `issue_instr_o` holds an entry.
- `issue_ack_i` in 1: issue consumed `issue_instr_o`.
- `rs1_i`, `rs2_i` in 5: operand registers to look up.
- `rs1_o`, `rs2_o` out 64: forwarded result.
- `rs1_valid_o`, `rs2_valid_o` out 1: forward hit.
- `trans_id_i` in `NR_WB_PORTS`×`TRANS_ID_BITS`: write-back entry index.
- `wdata_i` in `NR_WB_PORTS`×64: write-back result.
- `wb_valid_i` in `NR_WB_PORTS`: write-back strobe.
- `ex_i` in `NR_WB_PORTS`×`exception`: write-back exception.
- `commit_instr_o` out `scoreboard_entry`: oldest entry.
- `commit_valid_o` out 1: buffer non-empty.
- `commit_ack_i` in 1: commit retires the oldest entry.

## Operation
- State:
  - entry array `mem[NR_ENTRIES]`
  - `decode_ptr`, `issue_ptr`, `commit_ptr`, each `TRANS_ID_BITS` wide, wrapping modulo `NR_ENTRIES`
  - `cnt` (0..`NR_ENTRIES`), occupancy
  - `issue_cnt` (0..`cnt`), number of entries not yet issued
- Allocate: when `decoded_instr_valid_i && !full_o`:
  - write `mem[decode_ptr]` from `decoded_instr_i`, overriding `trans_id`=`decode_ptr` and `valid`=0
  - increment `decode_ptr`, `cnt` and `issue_cnt`
- Issue:
  - `issue_instr_o`=`mem[issue_ptr]`; `issue_instr_valid_o`=(`issue_cnt`!=0)
  - `issue_ack_i` is honoured only while valid; it increments `issue_ptr` and decrements `issue_cnt`.
- Write-back: for each port p with `wb_valid_i[p]`:
  - `mem[trans_id_i[p]].result`=`wdata_i[p]` and `.valid`=1
  - if `ex_i[p].valid`, `.ex`=`ex_i[p]`
  - if two ports target the same id in one cycle, the higher port index wins
  - write-back to an unallocated id is ignored
- Commit:
  - `commit_instr_o`=`mem[commit_ptr]`; `commit_valid_o`=(`cnt`!=0)
  - commit itself checks `.valid`; `commit_ack_i` is honoured only while `commit_valid_o`
  - on ack, increment `commit_ptr`, decrement `cnt`, and clear that entry's `valid`
- Forwarding, combinational:
  - search issued, uncommitted entries with `rd`==`rs1_i` and `valid`=1
  - the youngest such entry (closest to `issue_ptr`) supplies `rs1_o`; `rs1_valid_o`=1 on a hit
  - the search does not stop at an older hit: if the youngest writer of that `rd` has `valid`=0, `rs1_valid_o`=0
  - `rs1_i`==0 never hits; no hit gives `rs1_o`=0
  - `rs2` is identical
- Simultaneous events:
  - allocate and commit in one cycle: `cnt` is unchanged
  - issue and allocate in one cycle: `issue_cnt` is unchanged
  - `full_o` comes from the registered `cnt`; there is no same-cycle bypass, so no allocate when `cnt`==`NR_ENTRIES` even if commit acks
  - write-back and commit of the same entry in one cycle: the commit sees the pre-write-back contents
- Flush (`flush_i`):
  - next cycle: all pointers, `cnt` and `issue_cnt` are 0 and every `valid`/`ex.valid` is cleared
  - flush overrides allocate, issue, write-back and commit in the same cycle
- Reset: same as flush, and all entry fields are zeroed.

## Timing
- Outputs after reset or flush: `full_o`=0, `decoded_instr_ack_o`=1, `issue_instr_valid_o`=0, `commit_valid_o`=0, `rs*_valid_o`=0, `rs*_o`=0, `issue_instr_o`/`commit_instr_o` all zero.
- Latencies:
  - allocate to `issue_instr_valid_o`: 1 cycle
  - write-back to `commit_instr_o.valid` and to forwarding: 1 cycle
  - ack to pointer advance: 1 cycle
- Combinational paths:
  - `decoded_instr_ack_o`, `issue_instr_o`, `commit_instr_o` depend only on registered state
  - `rs*_o`/`rs*_valid_o` are combinational from `rs*_i` and state
  - there is no path from any `*_ack_i` to any output

## Structure
- The shared package holds `scoreboard_entry`, `exception`, `fu_t`, `NR_SB_ENTRIES`, `TRANS_ID_BITS` and `NR_WB_PORTS`.
- No constants are local to this block.
- No sub-module. Forwarding search is a local function instantiated twice (rs1, rs2).

## Test plan
- Reset, then 4 allocates with `rd`=1..4 and no ack → `trans_id` 0..3 issued in order, `full_o`=1 after the 4th, 5th instruction not acked.
- Full buffer, `commit_ack_i` and `decoded_instr_valid_i` in same cycle → no allocate that cycle, `full_o`=0 next cycle, allocate lands at `trans_id` 0 (wrap).
- Entries 0,1 issued with `rd`=5, write-back id 1 `wdata`=0xDEAD, then write-back id 0 `wdata`=0xBEEF, `rs1_i`=5 → `rs1_o`=0xDEAD, `rs1_valid_o`=1.
- `rs1_i`=5 with no write-back yet → `rs1_valid_o`=0. `rs1_i`=0 → `rs1_valid_o`=0 even when an entry has `rd`=0 and is valid.
- Ports 0 and 2 write id 2 in one cycle, port 2 with `ex.cause`=`ILLEGAL_INSTR` → entry 2 holds port-2 data and exception `valid`=1.
- 3 entries allocated, `flush_i` coincident with allocate, write-back and commit ack → next cycle `commit_valid_o`=0, `issue_instr_valid_o`=0, next allocate gets `trans_id` 0.
